os_decoder: RTL and testbench
=============================

Name: os_decoder

Overview:
- Receive-side counterpart of the LTSSM ordered-set generator.
- Accepts the per-lane 4-beat AXI-Stream ordered-set format from the PHY RX path and reassembles 16-symbol ordered sets per lane.
- Classifies each set as TS1, TS2, EIOS, logical idle or unknown, checks lane consistency, and counts identical consecutive sets.
- Outputs feed the LTSSM's receive-condition logic.

Parameters:
- MAX_NUM_LANES, 4, lanes carried in parallel on the stream.
- DATA_WIDTH, 32, per-lane data bits per beat.
- KEEP_WIDTH, DATA_WIDTH/8, per-lane keep bits.
- USER_WIDTH, 4, per-lane user bits; only tuser[USER_WIDTH-1:0] is used, as K flags common to all lanes.
- CONSEC_TARGET, 8, identical-set count that asserts consec_reached_o.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- s_axis_tdata, in, DATA_WIDTH*MAX_NUM_LANES, lane i at [32*i+:32], byte 0 in the LSBs.
- s_axis_tkeep, in, KEEP_WIDTH*MAX_NUM_LANES, ignored; all-ones expected.
- s_axis_tvalid, in, 1, beat valid.
- s_axis_tlast, in, 1, final beat of a set.
- s_axis_tuser, in, USER_WIDTH*MAX_NUM_LANES, bit j set means byte j of this beat is a K symbol.
- s_axis_tready, out, 1, 0 in reset, 1 otherwise; no backpressure.
- active_lanes_i, in, MAX_NUM_LANES, mask of lanes checked for consistency (bit 0 is always treated as set).
- ordered_set_o, out, pcie_ordered_set_t, lane-0 set, registered.
- lane_num_o, out, 8*MAX_NUM_LANES, byte 2 of each lane.
- os_valid_o, out, 1, one-cycle pulse when a new set is reported.
- os_type_o, out, os_type_e, class of the reported set.
- consec_cnt_o, out, 8, count of identical consecutive sets.
- consec_reached_o, out, 1, consec_cnt_o >= CONSEC_TARGET.
- lane_mismatch_o, out, 1, pulse accompanying os_valid_o.
- framing_err_o, out, 1, one-cycle pulse.

Behaviour:
- Reset values:
  - All outputs 0; os_type_o = OS_NONE; s_axis_tready = 0.
  - Any partially collected set is discarded.
  - consec_cnt_o and the stored previous set are cleared.
- A beat is accepted when s_axis_tvalid && s_axis_tready. Idle cycles (tvalid = 0) may occur between beats and are ignored.
- Beat index b = 0..3 carries bytes 4b..4b+3 of each lane. The K flags of beat b go to K bits 4b..4b+3.
- States:
  - ST_IDLE: waits for beat 0. Beat 0 is accepted as the start of a set if either:
    - byte 0 is COM_ (0xBC) with K[0]=1, or
    - all 4 bytes are 0x00 with K=0 (logical idle candidate).
    - On acceptance, store the beat and go to ST_COLLECT with b=1.
    - Otherwise pulse framing_err_o; go to ST_DROP if tlast=0, or stay in ST_IDLE if tlast=1.
  - ST_COLLECT:
    - Store beats b=1..3.
    - tlast on b<3, or no tlast on b=3: pulse framing_err_o and discard the set. Go to ST_IDLE if tlast=1, else ST_DROP.
    - Valid b=3 with tlast: go to ST_IDLE and arm reporting.
  - ST_DROP: discard beats until one with tlast, then go to ST_IDLE.
- Reporting happens one cycle after the tlast beat is accepted:
  - os_valid_o pulses; ordered_set_o, lane_num_o, os_type_o, lane_mismatch_o and the counter update in the same cycle.
  - A new beat 0 may be accepted in that same cycle, so back-to-back sets stream at full rate.
- Classification, from lane 0:
  - Bytes 1..3 = IDL_ (0x7C) with K set: OS_EIOS.
  - Otherwise byte 10 = 0x4A: OS_TS1.
  - Otherwise byte 10 = 0x45: OS_TS2.
  - All 16 bytes 0x00 with no K: OS_IDLE.
  - Otherwise: OS_UNKNOWN.
  - TS1/TS2 requires bytes 10..15 all equal to the identifier; otherwise OS_UNKNOWN.
- lane_mismatch_o = 1 if any active lane differs from lane 0 in any byte other than byte 2. Applies to TS1/TS2 only.
- Consecutive counter:
  - If the new lane-0 set is identical (16 bytes and K bits) to the previous one and the type is not OS_UNKNOWN: increment, saturating at 255.
  - Otherwise: load 1; OS_UNKNOWN loads 0.
  - A framing error clears the counter to 0 and clears the stored previous set.
- Reset asserted mid-set: everything returns to reset values on the next edge; no report is emitted for the partial set.

Decomposition:
- pcie_phy_pkg gains:
  - COM_, IDL_, TS1_ID_, TS2_ID_ constants.
  - os_type_e {OS_NONE, OS_TS1, OS_TS2, OS_EIOS, OS_IDLE, OS_UNKNOWN}.
  - A classify function taking 16 bytes plus 16 K bits and returning os_type_e.
- Reuse the existing pcie_ordered_set_t.
- No sub-module; the block is a single Q/D struct-style FSM with a 16-byte × MAX_NUM_LANES assembly buffer.

Test Plan:
- Four beats of a TS1 (link 0x00, lanes 0..3 with lane_num=i, bytes 10..15 = 0x4A), K=0x1 on beat 0 -> one cycle after tlast: os_valid_o=1, os_type_o=OS_TS1, lane_num_o=0x03020100, lane_mismatch_o=0, consec_cnt_o=1.
- The same TS2 sent 9 times back-to-back with no gaps -> 9 os_valid_o pulses on consecutive 4-cycle boundaries; consec_cnt_o counts 1..9; consec_reached_o rises with the 8th report.
- EIOS (COM + 3×IDL, K=0xF on every beat) -> os_type_o=OS_EIOS. Then a TS1 -> consec_cnt_o=1.
- tlast asserted on beat 2 -> framing_err_o pulses once, no os_valid_o, consec_cnt_o=0. The next well-formed set reports normally.
- Lane 2 byte 5 corrupted in a TS1 with active_lanes_i=0xF -> lane_mismatch_o=1. Same stimulus with active_lanes_i=0x3 -> lane_mismatch_o=0.
- rst_i pulsed after beat 1 -> no report, s_axis_tready=0 during reset, all outputs 0. Beats 2..3 after reset are treated as non-COM beat 0 -> framing_err_o, then ST_DROP until tlast.

Source files
------------

// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY definitions: ordered-set symbols, the ordered-set container,
// receive-side set classes and the decoder state encoding.
package pcie_phy_pkg;

    localparam logic [7:0] COM_    = 8'hBC;
    localparam logic [7:0] IDL_    = 8'h7C;
    localparam logic [7:0] TS1_ID_ = 8'h4A;
    localparam logic [7:0] TS2_ID_ = 8'h45;

    typedef struct packed {
        logic [15:0]      is_k;
        logic [15:0][7:0] symbols;
    } pcie_ordered_set_t;

    typedef enum logic [2:0] {
        OS_NONE,
        OS_TS1,
        OS_TS2,
        OS_EIOS,
        OS_IDLE,
        OS_UNKNOWN
    } os_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DROP
    } os_dec_state_e;

    function automatic logic ts_tail_ok(input logic [15:0][7:0] sym, input logic [7:0] id);
        logic ok;
        ok = 1'b1;
        for (int i = 10; i < 16; i++) begin
            if (sym[i] != id) ok = 1'b0;
        end
        return ok;
    endfunction

    // EIOS wins over TS identifiers; a TS needs its whole identifier tail intact.
    function automatic os_type_e classify(input logic [15:0][7:0] sym, input logic [15:0] k);
        os_type_e t;
        if (sym[1] == IDL_ && sym[2] == IDL_ && sym[3] == IDL_ && (&k[3:1])) begin
            t = OS_EIOS;
        end else if (sym[10] == TS1_ID_) begin
            t = ts_tail_ok(sym, TS1_ID_) ? OS_TS1 : OS_UNKNOWN;
        end else if (sym[10] == TS2_ID_) begin
            t = ts_tail_ok(sym, TS2_ID_) ? OS_TS2 : OS_UNKNOWN;
        end else if (sym == '0 && k == '0) begin
            t = OS_IDLE;
        end else begin
            t = OS_UNKNOWN;
        end
        return t;
    endfunction

endpackage

// File: rtl/os_decoder_if.sv
// Per-lane AXI-Stream bus carrying ordered sets as four beats per set.
interface os_decoder_if #(
    parameter int MAX_NUM_LANES = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int USER_WIDTH    = 4
);
    logic [DATA_WIDTH*MAX_NUM_LANES-1:0] tdata;
    logic [KEEP_WIDTH*MAX_NUM_LANES-1:0] tkeep;
    logic                                tvalid;
    logic                                tlast;
    logic [USER_WIDTH*MAX_NUM_LANES-1:0] tuser;
    logic                                tready;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/os_decoder.sv
// Receive-side ordered-set decoder: reassembles 16-symbol sets per lane, classifies
// the lane-0 set, checks lane consistency and counts identical consecutive sets.
module os_decoder
    import pcie_phy_pkg::*;
#(
    parameter int MAX_NUM_LANES = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int USER_WIDTH    = 4,
    parameter int CONSEC_TARGET = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    os_decoder_if.slave                  s_axis,
    input  logic [MAX_NUM_LANES-1:0]     active_lanes_i,
    output pcie_ordered_set_t            ordered_set_o,
    output logic [8*MAX_NUM_LANES-1:0]   lane_num_o,
    output logic                         os_valid_o,
    output os_type_e                     os_type_o,
    output logic [7:0]                   consec_cnt_o,
    output logic                         consec_reached_o,
    output logic                         lane_mismatch_o,
    output logic                         framing_err_o
);

    localparam int         SET_BITS   = 4 * DATA_WIDTH;
    localparam logic [7:0] CONSEC_TGT = 8'(CONSEC_TARGET);

    os_dec_state_e                                   state_q, state_d;
    logic [1:0]                                      beat_q, beat_d;
    logic [MAX_NUM_LANES-1:0][2:0][DATA_WIDTH-1:0]   buf_q, buf_d;
    logic [2:0][KEEP_WIDTH-1:0]                      k_q, k_d;
    pcie_ordered_set_t                               prev_q, prev_d;
    pcie_ordered_set_t                               set_q, set_d;
    logic [7:0]                                      cnt_q, cnt_d;
    logic                                            reached_q, reached_d;
    logic                                            valid_q, valid_d;
    logic                                            mismatch_q, mismatch_d;
    logic                                            ferr_q, ferr_d;
    os_type_e                                        type_q, type_d;
    logic [8*MAX_NUM_LANES-1:0]                      lane_num_q, lane_num_d;
    logic                                            tready_q;

    logic [MAX_NUM_LANES-1:0][DATA_WIDTH-1:0]        lane_word;
    logic [MAX_NUM_LANES-1:0][SET_BITS-1:0]          full_set;
    logic [MAX_NUM_LANES-1:0]                        lane_diff;
    logic [MAX_NUM_LANES-1:0]                        active_mask;
    logic [8*MAX_NUM_LANES-1:0]                      lane_num_w;
    logic [KEEP_WIDTH-1:0]                           k_beat;
    pcie_ordered_set_t                               new_set;
    os_type_e                                        new_type;
    logic                                            beat_accept;
    logic                                            start_ok;
    logic                                            is_ts;
    logic                                            unused_bits;

    assign unused_bits = ^{s_axis.tkeep, s_axis.tuser[USER_WIDTH*MAX_NUM_LANES-1:KEEP_WIDTH]};

    assign beat_accept = s_axis.tvalid && tready_q;
    assign k_beat      = s_axis.tuser[KEEP_WIDTH-1:0];
    assign active_mask = active_lanes_i | {{(MAX_NUM_LANES-1){1'b0}}, 1'b1};

    // The final beat is taken straight from the bus so the report can be registered on its edge.
    generate
        for (genvar gi = 0; gi < MAX_NUM_LANES; gi++) begin : g_lane
            assign lane_word[gi]          = s_axis.tdata[DATA_WIDTH*gi +: DATA_WIDTH];
            assign full_set[gi]           = {lane_word[gi], buf_q[gi]};
            assign lane_num_w[8*gi +: 8]  = full_set[gi][23:16];
            assign lane_diff[gi]          = active_mask[gi] &&
                ({full_set[gi][SET_BITS-1:24], full_set[gi][15:0]} !=
                 {full_set[0][SET_BITS-1:24],  full_set[0][15:0]});
        end
    endgenerate

    assign new_set.symbols = full_set[0];
    assign new_set.is_k    = {k_beat, k_q};
    assign new_type        = classify(new_set.symbols, new_set.is_k);
    assign is_ts           = (new_type == OS_TS1) || (new_type == OS_TS2);

    assign start_ok = (lane_word[0][7:0] == COM_ && k_beat[0]) ||
                      (lane_word[0] == '0 && k_beat == '0);

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        buf_d      = buf_q;
        k_d        = k_q;
        prev_d     = prev_q;
        cnt_d      = cnt_q;
        set_d      = set_q;
        type_d     = type_q;
        lane_num_d = lane_num_q;
        valid_d    = 1'b0;
        mismatch_d = 1'b0;
        ferr_d     = 1'b0;
        if (beat_accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        for (int l = 0; l < MAX_NUM_LANES; l++) buf_d[l][0] = lane_word[l];
                        k_d[0]  = k_beat;
                        beat_d  = 2'd1;
                        state_d = ST_COLLECT;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = s_axis.tlast ? ST_IDLE : ST_DROP;
                    end
                end
                ST_COLLECT: begin
                    if (s_axis.tlast != (beat_q == 2'd3)) begin
                        ferr_d  = 1'b1;
                        state_d = s_axis.tlast ? ST_IDLE : ST_DROP;
                    end else if (s_axis.tlast) begin
                        state_d    = ST_IDLE;
                        valid_d    = 1'b1;
                        set_d      = new_set;
                        type_d     = new_type;
                        lane_num_d = lane_num_w;
                        mismatch_d = is_ts && (|lane_diff);
                        prev_d     = new_set;
                        if (new_type == OS_UNKNOWN) begin
                            cnt_d = 8'd0;
                        end else if (new_set == prev_q) begin
                            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                        end else begin
                            cnt_d = 8'd1;
                        end
                    end else begin
                        for (int l = 0; l < MAX_NUM_LANES; l++) begin
                            if (beat_q == 2'd1) buf_d[l][1] = lane_word[l];
                            else                buf_d[l][2] = lane_word[l];
                        end
                        if (beat_q == 2'd1) k_d[1] = k_beat;
                        else                k_d[2] = k_beat;
                        beat_d = beat_q + 2'd1;
                    end
                end
                ST_DROP: begin
                    if (s_axis.tlast) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (ferr_d) begin
            cnt_d  = 8'd0;
            prev_d = '0;
        end
        reached_d = (cnt_d >= CONSEC_TGT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            buf_q      <= '0;
            k_q        <= '0;
            prev_q     <= '0;
            set_q      <= '0;
            cnt_q      <= '0;
            reached_q  <= 1'b0;
            valid_q    <= 1'b0;
            mismatch_q <= 1'b0;
            ferr_q     <= 1'b0;
            type_q     <= OS_NONE;
            lane_num_q <= '0;
            tready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            buf_q      <= buf_d;
            k_q        <= k_d;
            prev_q     <= prev_d;
            set_q      <= set_d;
            cnt_q      <= cnt_d;
            reached_q  <= reached_d;
            valid_q    <= valid_d;
            mismatch_q <= mismatch_d;
            ferr_q     <= ferr_d;
            type_q     <= type_d;
            lane_num_q <= lane_num_d;
            tready_q   <= 1'b1;
        end
    end

    assign s_axis.tready    = tready_q;
    assign ordered_set_o    = set_q;
    assign lane_num_o       = lane_num_q;
    assign os_valid_o       = valid_q;
    assign os_type_o        = type_q;
    assign consec_cnt_o     = cnt_q;
    assign consec_reached_o = reached_q;
    assign lane_mismatch_o  = mismatch_q;
    assign framing_err_o    = ferr_q;

endmodule

// File: tb/tb_os_decoder.sv
// Directed bench for os_decoder: expected reports are queued as sets are sent and
// checked against each os_valid_o pulse.
module tb_os_decoder;
    import pcie_phy_pkg::*;

    localparam int CLK_PERIOD = 10;

    typedef logic [3:0][127:0] lanes_t;

    typedef struct {
        os_type_e     t;
        logic [31:0]  ln;
        logic         mm;
        logic [7:0]   cnt;
        logic         rch;
        logic [127:0] sym;
        logic [15:0]  k;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [3:0]        active_lanes_i;
    pcie_ordered_set_t ordered_set_o;
    logic [31:0]       lane_num_o;
    logic              os_valid_o;
    os_type_e          os_type_o;
    logic [7:0]        consec_cnt_o;
    logic              consec_reached_o;
    logic              lane_mismatch_o;
    logic              framing_err_o;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     fe_cnt   = 0;
    exp_t   exp_q[$];
    longint vt_q[$];

    os_decoder_if #(.MAX_NUM_LANES(4), .DATA_WIDTH(32), .USER_WIDTH(4)) axis ();

    os_decoder #(
        .MAX_NUM_LANES(4), .DATA_WIDTH(32), .USER_WIDTH(4), .CONSEC_TARGET(8)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .s_axis           (axis),
        .active_lanes_i   (active_lanes_i),
        .ordered_set_o    (ordered_set_o),
        .lane_num_o       (lane_num_o),
        .os_valid_o       (os_valid_o),
        .os_type_o        (os_type_o),
        .consec_cnt_o     (consec_cnt_o),
        .consec_reached_o (consec_reached_o),
        .lane_mismatch_o  (lane_mismatch_o),
        .framing_err_o    (framing_err_o)
    );

    always #(CLK_PERIOD/2) clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] req);
        n_checks++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic drive_beat(input logic [127:0] data, input logic [3:0] k, input logic last);
        axis.tdata  = data;
        axis.tuser  = {12'h000, k};
        axis.tkeep  = '1;
        axis.tvalid = 1'b1;
        axis.tlast  = last;
        @(posedge clk_i);
        #1;
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
    endtask

    task automatic send_set(input lanes_t d, input logic [15:0] k, input int first,
                            input int count, input int last_beat);
        logic [127:0] w;
        for (int b = first; b < first + count; b++) begin
            for (int l = 0; l < 4; l++) w[32*l +: 32] = d[l][32*b +: 32];
            drive_beat(w, k[4*b +: 4], b == last_beat);
        end
    endtask

    function automatic lanes_t make_ts(input logic [7:0] id);
        lanes_t           d;
        logic [15:0][7:0] s;
        for (int l = 0; l < 4; l++) begin
            s[0] = COM_; s[1] = 8'h00; s[2] = 8'(l); s[3] = 8'h1F;
            s[4] = 8'h02; s[5] = 8'h00;
            for (int i = 6; i < 16; i++) s[i] = id;
            d[l] = s;
        end
        return d;
    endfunction

    task automatic expect_os(input os_type_e t, input lanes_t d, input logic [15:0] k,
                             input logic mm, input int cnt);
        exp_t e;
        e.t   = t;
        e.ln  = {d[3][23:16], d[2][23:16], d[1][23:16], d[0][23:16]};
        e.mm  = mm;
        e.cnt = 8'(cnt);
        e.rch = (cnt >= 8);
        e.sym = d[0];
        e.k   = k;
        exp_q.push_back(e);
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (os_valid_o) begin
            vt_q.push_back($time);
            if (exp_q.size() == 0) begin
                chk("unexpected_report", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("os_type",        os_type_o,             e.t);
                chk("lane_num",       lane_num_o,            e.ln);
                chk("lane_mismatch",  lane_mismatch_o,       e.mm);
                chk("consec_cnt",     consec_cnt_o,          e.cnt);
                chk("consec_reached", consec_reached_o,      e.rch);
                chk("os_symbols",     ordered_set_o.symbols, e.sym);
                chk("os_k",           ordered_set_o.is_k,    e.k);
            end
        end
        if (framing_err_o) fe_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        lanes_t ts1, ts2, eios, idl, bad, unk;
        int     fe0;
        ts1  = make_ts(TS1_ID_);
        ts2  = make_ts(TS2_ID_);
        eios = {4{ {4{32'h7C7C7CBC}} }};
        idl  = '0;
        bad  = ts1;
        bad[2][5*8 +: 8] = 8'hFF;
        unk  = ts1;
        unk[0][12*8 +: 8] = 8'h00;

        rst_i = 1'b1;
        active_lanes_i = 4'hF;
        axis.tdata = '0; axis.tuser = '0; axis.tkeep = '1;
        axis.tvalid = 1'b0; axis.tlast = 1'b0;

        // Reset state
        idle(3);
        chk("rst_tready",   axis.tready,      0);
        chk("rst_os_valid", os_valid_o,       0);
        chk("rst_os_type",  os_type_o,        OS_NONE);
        chk("rst_consec",   consec_cnt_o,     0);
        chk("rst_reached",  consec_reached_o, 0);
        chk("rst_set",      ordered_set_o,    0);
        chk("rst_lane_num", lane_num_o,       0);
        chk("rst_ferr",     framing_err_o,    0);
        rst_i = 1'b0;
        idle(1);
        chk("tready_after_rst", axis.tready, 1);

        // Single TS1
        expect_os(OS_TS1, ts1, 16'h0001, 1'b0, 1);
        send_set(ts1, 16'h0001, 0, 4, 3);
        idle(4);
        chk("ts1_lane_num_literal", lane_num_o, 32'h03020100);

        // Nine identical TS2 back-to-back
        vt_q.delete();
        for (int i = 0; i < 9; i++) begin
            expect_os(OS_TS2, ts2, 16'h0001, 1'b0, i + 1);
            send_set(ts2, 16'h0001, 0, 4, 3);
        end
        idle(4);
        chk("ts2_report_count", vt_q.size(), 9);
        for (int i = 1; i < 9 && i < vt_q.size(); i++)
            chk("ts2_spacing", vt_q[i] - vt_q[i-1], 4 * CLK_PERIOD);

        // EIOS then TS1
        expect_os(OS_EIOS, eios, 16'hFFFF, 1'b0, 1);
        send_set(eios, 16'hFFFF, 0, 4, 3);
        expect_os(OS_TS1, ts1, 16'h0001, 1'b0, 1);
        send_set(ts1, 16'h0001, 0, 4, 3);
        idle(4);

        // tlast on beat 2
        fe0 = fe_cnt;
        send_set(ts1, 16'h0001, 0, 3, 2);
        idle(4);
        chk("early_tlast_ferr", fe_cnt - fe0, 1);
        chk("early_tlast_cnt",  consec_cnt_o, 0);
        expect_os(OS_TS1, ts1, 16'h0001, 1'b0, 1);
        send_set(ts1, 16'h0001, 0, 4, 3);
        expect_os(OS_TS1, ts1, 16'h0001, 1'b0, 2);
        send_set(ts1, 16'h0001, 0, 4, 3);
        idle(4);

        // Lane 2 byte 5 corrupted
        expect_os(OS_TS1, bad, 16'h0001, 1'b1, 3);
        send_set(bad, 16'h0001, 0, 4, 3);
        idle(4);
        active_lanes_i = 4'h3;
        expect_os(OS_TS1, bad, 16'h0001, 1'b0, 4);
        send_set(bad, 16'h0001, 0, 4, 3);
        idle(4);
        active_lanes_i = 4'hF;

        // Logical idle sets
        expect_os(OS_IDLE, idl, 16'h0000, 1'b0, 1);
        send_set(idl, 16'h0000, 0, 4, 3);
        expect_os(OS_IDLE, idl, 16'h0000, 1'b0, 2);
        send_set(idl, 16'h0000, 0, 4, 3);
        idle(4);

        // Broken TS tail, then a single-beat garbage set
        expect_os(OS_UNKNOWN, unk, 16'h0001, 1'b0, 0);
        send_set(unk, 16'h0001, 0, 4, 3);
        idle(4);
        fe0 = fe_cnt;
        drive_beat({4{32'h00000055}}, 4'h0, 1'b1);
        idle(4);
        chk("garbage_ferr", fe_cnt - fe0, 1);
        expect_os(OS_TS1, ts1, 16'h0001, 1'b0, 1);
        send_set(ts1, 16'h0001, 0, 4, 3);
        idle(4);

        // Reset in the middle of a set
        send_set(ts1, 16'h0001, 0, 2, 3);
        rst_i = 1'b1;
        idle(1);
        chk("midrst_tready", axis.tready,   0);
        chk("midrst_valid",  os_valid_o,    0);
        chk("midrst_type",   os_type_o,     OS_NONE);
        chk("midrst_cnt",    consec_cnt_o,  0);
        chk("midrst_set",    ordered_set_o, 0);
        rst_i = 1'b0;
        idle(1);
        fe0 = fe_cnt;
        send_set(ts1, 16'h0001, 2, 2, 3);
        idle(4);
        chk("midrst_tail_ferr", fe_cnt - fe0, 1);
        expect_os(OS_TS1, ts1, 16'h0001, 1'b0, 1);
        send_set(ts1, 16'h0001, 0, 4, 3);
        idle(4);

        // Counter saturation
        for (int i = 0; i < 260; i++) begin
            expect_os(OS_TS2, ts2, 16'h0001, 1'b0, (i + 1 > 255) ? 255 : i + 1);
            send_set(ts2, 16'h0001, 0, 4, 3);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk_i);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
